// File: rtl/apb_dec_pkg.sv
// Shared types and the address-region-to-slot map for apb_periph_decoder.
package apb_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] SLV_I2C   = 3'd0;
  localparam logic [2:0] SLV_SPI   = 3'd1;
  localparam logic [2:0] SLV_GPIO  = 3'd2;
  localparam logic [2:0] SLV_INT   = 3'd3;
  localparam logic [2:0] SLV_SPARE = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } slot_sel_t;

  // The spare port sits at region 0x3 and INT at 0x4, so slot order != region order.
  function automatic slot_sel_t region_to_slot(input logic [3:0] region);
    slot_sel_t r;
    r.valid = 1'b1;
    r.idx   = SLV_I2C;
    case (region)
      4'h0:    r.idx = SLV_I2C;
      4'h1:    r.idx = SLV_SPI;
      4'h2:    r.idx = SLV_GPIO;
      4'h3:    r.idx = SLV_SPARE;
      4'h4:    r.idx = SLV_INT;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/apb_periph_decoder.sv
// Registered APB3 decode/response stage for the I2C/SPI/GPIO/INT peripheral cluster.
// Define APB_DEC_TIMEOUT_EN to add a hung-slave timeout in the ACCESS phase.
module apb_periph_decoder
  import apb_dec_pkg::*;
#(
  parameter int unsigned APB_DW      = 32,
  parameter int unsigned APB_AW      = 12,
  parameter int unsigned NUM_SLV     = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                      clk_apb,
  input  logic                      rst_apb_n,
  input  logic [APB_AW-1:0]         paddr,
  input  logic                      pwrite,
  input  logic [APB_DW-1:0]         pwdata,
  input  logic                      psel,
  input  logic                      penable,
  output logic [APB_DW-1:0]         prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [NUM_SLV-1:0]        m_psel,
  output logic                      m_penable,
  output logic [APB_AW-1:0]         m_paddr,
  output logic                      m_pwrite,
  output logic [APB_DW-1:0]         m_pwdata,
  input  logic [NUM_SLV*APB_DW-1:0] s_prdata,
  input  logic [NUM_SLV-1:0]        s_pready,
  input  logic [NUM_SLV-1:0]        s_pslverr,
  output logic                      dec_err
);

  state_t             state, state_nxt;
  slot_sel_t          dec;
  logic [2:0]         idx;
  logic               setup_req;
  logic               sel_ready;
  logic               sel_err;
  logic [APB_DW-1:0]  sel_data;
  logic               timeout_hit;

  always_comb begin
    dec       = region_to_slot(paddr[APB_AW-1 -: 4]);
    setup_req = psel & ~penable;
  end

  // Only the captured slot's response is looked at; the others are don't-care.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (idx == 3'(i)) begin
        sel_ready = s_pready[i];
        sel_err   = s_pslverr[i];
        sel_data  = s_prdata[i*APB_DW +: APB_DW];
      end
    end
  end

`ifdef APB_DEC_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk_apb) begin
    if (!rst_apb_n) begin
      to_cnt <= '0;
    end else if (state_nxt == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !sel_ready) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  always_comb begin
    timeout_hit = (state == ACCESS) && !sel_ready && (to_cnt == 16'(TIMEOUT_CYC - 1));
  end
`else
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  always_ff @(posedge clk_apb) begin
    if (!rst_apb_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_psel    = '0;
    m_penable = 1'b0;
    pready    = 1'b0;
    case (state)
      IDLE: begin
        if (setup_req) begin
          state_nxt = dec.valid ? SETUP : RESP;
        end
      end
      SETUP: begin
        m_psel[idx] = 1'b1;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        m_psel[idx] = 1'b1;
        m_penable   = 1'b1;
        if (sel_ready || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        pready    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // prdata/pslverr are loaded on RESP entry and cleared on RESP exit.
  always_ff @(posedge clk_apb) begin
    if (!rst_apb_n) begin
      idx      <= '0;
      m_paddr  <= '0;
      m_pwrite <= 1'b0;
      m_pwdata <= '0;
      prdata   <= '0;
      pslverr  <= 1'b0;
      dec_err  <= 1'b0;
    end else begin
      dec_err <= 1'b0;
      case (state)
        IDLE: begin
          if (setup_req) begin
            m_paddr  <= paddr;
            m_pwrite <= pwrite;
            m_pwdata <= pwdata;
            idx      <= dec.idx;
            if (!dec.valid) begin
              prdata  <= '0;
              pslverr <= 1'b1;
              dec_err <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            prdata  <= m_pwrite ? '0 : sel_data;
            pslverr <= sel_err;
          end else if (timeout_hit) begin
            prdata  <= '0;
            pslverr <= 1'b1;
            dec_err <= 1'b1;
          end
        end
        RESP: begin
          prdata  <= '0;
          pslverr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_periph_decoder.sv
// Directed, table-driven bench for apb_periph_decoder (default and APB_DEC_TIMEOUT_EN builds).
module tb_apb_periph_decoder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned NS = 5;
  localparam int unsigned NO_SLOT = 7;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    int unsigned   waits;
    int unsigned   slot;
    logic [DW-1:0] sdata;
    logic          serr;
    logic [NS-1:0] exp_sel;
    logic [DW-1:0] exp_prdata;
    logic          exp_err;
    logic          exp_dec;
    int unsigned   exp_lat;
  } vec_t;

  logic             clk_apb = 1'b0;
  logic             rst_apb_n;
  logic [AW-1:0]    paddr;
  logic             pwrite;
  logic [DW-1:0]    pwdata;
  logic             psel;
  logic             penable;
  logic [DW-1:0]    prdata;
  logic             pready;
  logic             pslverr;
  logic [NS-1:0]    m_psel;
  logic             m_penable;
  logic [AW-1:0]    m_paddr;
  logic             m_pwrite;
  logic [DW-1:0]    m_pwdata;
  logic [NS*DW-1:0] s_prdata;
  logic [NS-1:0]    s_pready;
  logic [NS-1:0]    s_pslverr;
  logic             dec_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cycle_cnt = 0;
  int unsigned pready_cyc = 0;

  vec_t vecs[9];

  apb_periph_decoder #(
    .APB_DW(DW), .APB_AW(AW), .NUM_SLV(NS), .TIMEOUT_CYC(4)
  ) dut (
    .clk_apb(clk_apb), .rst_apb_n(rst_apb_n),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .dec_err(dec_err)
  );

  always #5 clk_apb = ~clk_apb;
  always @(posedge clk_apb) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_apb);
    #1;
  endtask

  // Non-selected slaves answer ready/error with junk data so a wrong selection shows.
  task automatic load_slaves(input int unsigned slot, input logic [DW-1:0] sdata, input logic serr);
    for (int i = 0; i < NS; i++) s_prdata[i*DW +: DW] = 32'hDEAD_0000 | 32'(i);
    s_pslverr = '1;
    s_pready  = '1;
    if (slot < NS) begin
      s_prdata[slot*DW +: DW] = sdata;
      s_pslverr[slot]         = serr;
      s_pready[slot]          = 1'b0;
    end
  endtask

  task automatic do_xfer(input vec_t v);
    int unsigned acc;
    int unsigned stray;
    bit done;
    acc = 0; stray = 0; done = 0;
    step();
    chk("idle_pready", {31'd0, pready}, 32'd0);
    paddr = v.addr; pwrite = v.write; pwdata = v.wdata; psel = 1'b1; penable = 1'b0;
    load_slaves(v.slot, v.sdata, v.serr);
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      step();
      penable = 1'b1;
      if (m_psel != '0 && m_psel != v.exp_sel) stray++;
      if (cyc == 1) begin
        chk("setup_psel", 32'(m_psel), 32'(v.exp_sel));
        if (v.slot < NS) begin
          chk("setup_penable", {31'd0, m_penable}, 32'd0);
          chk("cap_paddr", 32'(m_paddr), 32'(v.addr));
          chk("cap_pwrite", {31'd0, m_pwrite}, {31'd0, v.write});
          chk("cap_pwdata", m_pwdata, v.wdata);
        end
      end
      if (pready) begin
        done = 1;
        pready_cyc = cycle_cnt;
        chk("latency", 32'(cyc), 32'(v.exp_lat));
        chk("prdata", prdata, v.exp_prdata);
        chk("pslverr", {31'd0, pslverr}, {31'd0, v.exp_err});
        chk("dec_err", {31'd0, dec_err}, {31'd0, v.exp_dec});
        chk("resp_psel", 32'(m_psel), 32'd0);
      end else if (m_penable && v.slot < NS) begin
        acc++;
        if (acc > v.waits) s_pready[v.slot] = 1'b1;
      end
    end
    chk("xfer_done", {31'd0, done}, 32'd1);
    chk("stray_sel", stray, 32'd0);
  endtask

  task automatic go_idle();
    step();
    psel = 1'b0; penable = 1'b0; s_pready = '0;
  endtask

  initial begin
    int unsigned p1;
    int unsigned acc;
    bit seen;

    vecs[0] = '{12'h104, 1'b1, 32'hA5A5_0001, 0, 1, 32'hBBBB_0001, 1'b0, 5'b00010, 32'h0, 1'b0, 1'b0, 3};
    vecs[1] = '{12'h408, 1'b0, 32'h0, 3, 3, 32'h1234_5678, 1'b0, 5'b01000, 32'h1234_5678, 1'b0, 1'b0, 6};
    vecs[2] = '{12'h700, 1'b0, 32'h0, 0, NO_SLOT, 32'h0, 1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 1};
    vecs[3] = '{12'h3FC, 1'b0, 32'h0, 1, 4, 32'hCAFE_0004, 1'b1, 5'b10000, 32'hCAFE_0004, 1'b1, 1'b0, 4};
    vecs[4] = '{12'h2A0, 1'b1, 32'h0F0F_2A0A, 2, 2, 32'h7777_2222, 1'b1, 5'b00100, 32'h0, 1'b1, 1'b0, 5};
    vecs[5] = '{12'hF00, 1'b1, 32'h1111_1111, 0, NO_SLOT, 32'h0, 1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 1};
    vecs[6] = '{12'h5FF, 1'b0, 32'h0, 0, NO_SLOT, 32'h0, 1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 1};
    vecs[7] = '{12'h0FF, 1'b0, 32'h0, 0, 0, 32'h0000_00FF, 1'b0, 5'b00001, 32'h0000_00FF, 1'b0, 1'b0, 3};
    vecs[8] = '{12'h4FC, 1'b0, 32'h0, 0, 3, 32'h8000_0003, 1'b1, 5'b01000, 32'h8000_0003, 1'b1, 1'b0, 3};

    rst_apb_n = 1'b0;
    paddr = '0; pwrite = 1'b0; pwdata = '0; psel = 1'b0; penable = 1'b0;
    s_prdata = '0; s_pready = '0; s_pslverr = '0;
    repeat (3) step();
    chk("rst_outputs", {prdata | m_pwdata, 18'd0, m_paddr, 4'd0} |
        32'({pready, pslverr, m_psel, m_penable, m_pwrite, dec_err}), 32'd0);
    rst_apb_n = 1'b1;

    for (int i = 0; i < 9; i++) do_xfer(vecs[i]);
    go_idle();

    // Back-to-back reads on two slots: pready pulses four cycles apart.
    do_xfer('{12'h010, 1'b0, 32'h0, 0, 0, 32'h0000_0A10, 1'b0, 5'b00001, 32'h0000_0A10, 1'b0, 1'b0, 3});
    p1 = pready_cyc;
    do_xfer('{12'h210, 1'b0, 32'h0, 0, 2, 32'h0000_2A10, 1'b0, 5'b00100, 32'h0000_2A10, 1'b0, 1'b0, 3});
    chk("b2b_spacing", pready_cyc - p1, 32'd4);
    go_idle();

    // Upstream psel dropped during SETUP: downstream still completes and responds.
    step();
    paddr = 12'h108; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    load_slaves(1, 32'h5151_0108, 1'b0);
    s_pready[1] = 1'b1;
    step();
    psel = 1'b0;
    seen = 0;
    for (int cyc = 2; cyc <= 10 && !seen; cyc++) begin
      step();
      if (pready) begin
        seen = 1;
        chk("abort_lat", 32'(cyc), 32'd3);
        chk("abort_prdata", prdata, 32'h5151_0108);
      end
    end
    chk("abort_resp", {31'd0, seen}, 32'd1);
    go_idle();

    // Synchronous reset during ACCESS abandons the transfer.
    step();
    paddr = 12'h200; pwrite = 1'b1; pwdata = 32'h2222_0000; psel = 1'b1; penable = 1'b0;
    s_pready = '0;
    step();
    penable = 1'b1;
    step();
    step();
    chk("pre_rst_penable", {31'd0, m_penable}, 32'd1);
    rst_apb_n = 1'b0;
    step();
    chk("midrst_ctrl", 32'({pready, pslverr, m_psel, m_penable, m_pwrite, dec_err}), 32'd0);
    chk("midrst_data", prdata | m_pwdata | 32'(m_paddr), 32'd0);
    rst_apb_n = 1'b1; psel = 1'b0; penable = 1'b0;
    do_xfer('{12'h000, 1'b1, 32'h0000_5A5A, 0, 0, 32'h0, 1'b0, 5'b00001, 32'h0, 1'b0, 1'b0, 3});
    go_idle();

    // GPIO slave that never answers.
    step();
    paddr = 12'h200; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    load_slaves(2, 32'h6666_0200, 1'b0);
    acc = 0; seen = 0;
`ifdef APB_DEC_TIMEOUT_EN
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      step();
      penable = 1'b1;
      if (m_penable) acc++;
      if (pready) begin
        seen = 1;
        chk("to_lat", 32'(cyc), 32'd6);
        chk("to_pslverr", {31'd0, pslverr}, 32'd1);
        chk("to_dec_err", {31'd0, dec_err}, 32'd1);
        chk("to_prdata", prdata, 32'd0);
        chk("to_psel", 32'(m_psel), 32'd0);
      end
    end
    chk("to_access_cycles", acc, 32'd4);
    chk("to_resp", {31'd0, seen}, 32'd1);
`else
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      step();
      penable = 1'b1;
      if (m_penable && m_psel == 5'b00100) acc++;
      if (pready) seen = 1;
    end
    chk("wait_no_resp", {31'd0, seen}, 32'd0);
    chk("wait_access_cycles", acc, 32'd999);
    s_pready[2] = 1'b1;
    step();
    chk("late_pready", {31'd0, pready}, 32'd1);
    chk("late_prdata", prdata, 32'h6666_0200);
    chk("late_pslverr", {31'd0, pslverr}, 32'd0);
`endif
    go_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
